// File: rtl/conv_stream_pkg.sv
// Shared types and size helpers for the channel-planar serializer.
// Bank ownership states, read-side FSM states and derived frame geometry.
package conv_stream_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        GAP  = 2'd2
    } rd_state_e;

    function automatic int frame_words(input int channels, input int image_size);
        return channels * image_size;
    endfunction

    // Counter/address width that stays at least one bit for degenerate sizes.
    function automatic int cnt_width(input int range_len);
        return (range_len > 1) ? $clog2(range_len) : 1;
    endfunction

endpackage

// File: rtl/planar_bank_ram.sv
// Simple dual-port frame RAM holding both ping-pong banks.
// The bank select is the address MSB; the read port output is registered.
module planar_bank_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  wr_bank,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  rd_bank,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    // With a power-of-two frame this is exactly two frames deep.
    localparam int DEPTH = 2 ** (ADDR_WIDTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    // Output register holds its value between reads so pxl_out stays stable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end
    end

endmodule

// File: rtl/channel_planar_serializer.sv
// Reorders a pixel-interleaved multichannel stream into channel planes using
// two frame banks: one fills from the input while the other drains out.
module channel_planar_serializer
    import conv_stream_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int CHANNEL_NUM_IN = 4,
    parameter int IMAGE_SIZE     = 16,
    parameter int PLANE_GAP      = 0,
    parameter int FRAME_WORDS    = frame_words(CHANNEL_NUM_IN, IMAGE_SIZE),
    parameter int ADDR_WIDTH     = cnt_width(FRAME_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  plane_last,
    output logic                  frame_last,
    output logic                  overflow
);

    localparam int CH_W  = cnt_width(CHANNEL_NUM_IN);
    localparam int PX_W  = cnt_width(IMAGE_SIZE);
    localparam int GAP_W = 4;

    localparam logic [CH_W-1:0]       CH_LAST    = CH_W'(CHANNEL_NUM_IN - 1);
    localparam logic [PX_W-1:0]       PX_LAST    = PX_W'(IMAGE_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(FRAME_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] PLANE_SIZE = ADDR_WIDTH'(IMAGE_SIZE);
    localparam logic [GAP_W-1:0]      GAP_LAST   = GAP_W'(PLANE_GAP - 1);

    bank_state_e bank_state_reg [2];
    bank_state_e bank_state_next [2];

    logic            wr_bank_reg;
    logic [CH_W-1:0] ch_in_reg;
    logic [PX_W-1:0] px_in_reg;
    logic            overflow_reg;

    logic                  wr_open;
    logic                  wr_en;
    logic                  wr_drop;
    logic                  wr_last;
    logic [ADDR_WIDTH-1:0] wr_addr;

    rd_state_e             rd_state_reg, rd_state_next;
    logic                  rd_bank_reg, rd_bank_next;
    logic [ADDR_WIDTH-1:0] rd_addr_reg, rd_addr_next;
    logic [PX_W-1:0]       rd_px_reg, rd_px_next;
    logic [GAP_W-1:0]      gap_cnt_reg, gap_cnt_next;

    logic                  rd_start;
    logic                  rd_en;
    logic                  rd_claim_other;
    logic [ADDR_WIDTH-1:0] rd_addr_cur;
    logic [PX_W-1:0]       rd_px_cur;
    logic                  rd_plane_end;
    logic                  rd_frame_end;

    logic valid_out_reg, plane_last_reg, frame_last_reg;

    // ---------------------------------------------------------------- write side
    always_comb begin
        wr_open = (bank_state_reg[wr_bank_reg] == EMPTY) ||
                  (bank_state_reg[wr_bank_reg] == FILLING);
        wr_en   = valid_in && wr_open;
        wr_drop = valid_in && !wr_open;
        wr_last = wr_en && (ch_in_reg == CH_LAST) && (px_in_reg == PX_LAST);
        wr_addr = ADDR_WIDTH'(ch_in_reg) * PLANE_SIZE + ADDR_WIDTH'(px_in_reg);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bank_reg  <= 1'b0;
            ch_in_reg    <= '0;
            px_in_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_drop) begin
                overflow_reg <= 1'b1;
            end
            if (wr_en) begin
                if (wr_last) begin
                    ch_in_reg   <= '0;
                    px_in_reg   <= '0;
                    wr_bank_reg <= ~wr_bank_reg;
                end else if (ch_in_reg == CH_LAST) begin
                    ch_in_reg <= '0;
                    px_in_reg <= px_in_reg + 1'b1;
                end else begin
                    ch_in_reg <= ch_in_reg + 1'b1;
                end
            end
        end
    end

    // ----------------------------------------------------------------- read side
    // Address 0 is issued from IDLE in the same cycle the bank is seen FULL,
    // which is what gives the two-cycle input-to-output latency.
    always_comb begin
        rd_start     = (rd_state_reg == IDLE) && (bank_state_reg[rd_bank_reg] == FULL);
        rd_en        = rd_start || (rd_state_reg == READ);
        rd_addr_cur  = rd_start ? '0 : rd_addr_reg;
        rd_px_cur    = rd_start ? '0 : rd_px_reg;
        rd_plane_end = (rd_px_cur == PX_LAST);
        rd_frame_end = (rd_addr_cur == ADDR_LAST);
    end

    always_comb begin
        rd_state_next  = rd_state_reg;
        rd_bank_next   = rd_bank_reg;
        rd_addr_next   = rd_addr_reg;
        rd_px_next     = rd_px_reg;
        gap_cnt_next   = gap_cnt_reg;
        rd_claim_other = 1'b0;
        if (rd_en) begin
            if (rd_frame_end) begin
                rd_bank_next = ~rd_bank_reg;
                rd_addr_next = '0;
                rd_px_next   = '0;
                if (bank_state_reg[~rd_bank_reg] == FULL) begin
                    rd_state_next  = READ;
                    rd_claim_other = 1'b1;
                end else begin
                    rd_state_next = IDLE;
                end
            end else begin
                rd_addr_next = rd_addr_cur + 1'b1;
                rd_px_next   = rd_plane_end ? '0 : rd_px_cur + 1'b1;
                if (rd_plane_end && (PLANE_GAP > 0)) begin
                    rd_state_next = GAP;
                    gap_cnt_next  = '0;
                end else begin
                    rd_state_next = READ;
                end
            end
        end else if (rd_state_reg == GAP) begin
            if (gap_cnt_reg == GAP_LAST) begin
                rd_state_next = READ;
            end else begin
                gap_cnt_next = gap_cnt_reg + 1'b1;
            end
        end
    end

    // Write and read sides only ever act on banks in disjoint states, so the
    // updates below never compete for the same bank in one cycle.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_state_next[b] = bank_state_reg[b];
            if (wr_en && (wr_bank_reg == 1'(b))) begin
                bank_state_next[b] = wr_last ? FULL : FILLING;
            end
            if (rd_start && (rd_bank_reg == 1'(b))) begin
                bank_state_next[b] = DRAINING;
            end
            if (rd_claim_other && (rd_bank_reg != 1'(b))) begin
                bank_state_next[b] = DRAINING;
            end
            if (rd_en && rd_frame_end && (rd_bank_reg == 1'(b))) begin
                bank_state_next[b] = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                bank_state_reg[b] <= EMPTY;
            end
            rd_state_reg   <= IDLE;
            rd_bank_reg    <= 1'b0;
            rd_addr_reg    <= '0;
            rd_px_reg      <= '0;
            gap_cnt_reg    <= '0;
            valid_out_reg  <= 1'b0;
            plane_last_reg <= 1'b0;
            frame_last_reg <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                bank_state_reg[b] <= bank_state_next[b];
            end
            rd_state_reg   <= rd_state_next;
            rd_bank_reg    <= rd_bank_next;
            rd_addr_reg    <= rd_addr_next;
            rd_px_reg      <= rd_px_next;
            gap_cnt_reg    <= gap_cnt_next;
            valid_out_reg  <= rd_en;
            plane_last_reg <= rd_en && rd_plane_end;
            frame_last_reg <= rd_en && rd_frame_end;
        end
    end

    planar_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_bank (wr_bank_reg),
        .wr_addr (wr_addr),
        .wr_data (pxl_in),
        .rd_en   (rd_en),
        .rd_bank (rd_bank_reg),
        .rd_addr (rd_addr_cur),
        .rd_data (pxl_out)
    );

    assign valid_out  = valid_out_reg;
    assign plane_last = plane_last_reg;
    assign frame_last = frame_last_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_channel_planar_serializer.sv
// Directed bench for channel_planar_serializer: three instances (plane gaps
// 0, 3 and 15) driven one at a time, checked against a planar-order queue model.
module tb_channel_planar_serializer;

    localparam int C  = 4;
    localparam int S  = 16;
    localparam int FW = C * S;

    typedef struct packed {
        logic [31:0] d;
        logic        pl;
        logic        fl;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       vin = '0;
    logic [31:0]      pin = '0;
    logic [2:0][31:0] pout;
    logic [2:0]       vout, pl, fl, ovf;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   sel = 0;
    exp_t exp_q[$];

    int          out_cnt, first_cyc, prev_cyc, max_inner, max_all, pl_cnt, fl_cnt, last_drive;
    logic [31:0] first_data, last_fl_data;
    logic        prev_pl, prev_fl, last_was_fl;
    int          gap_pl_q[$];

    channel_planar_serializer #(.DATA_WIDTH(32), .CHANNEL_NUM_IN(C), .IMAGE_SIZE(S), .PLANE_GAP(0)) dut0 (
        .clk(clk), .reset(reset), .valid_in(vin[0]), .pxl_in(pin), .pxl_out(pout[0]),
        .valid_out(vout[0]), .plane_last(pl[0]), .frame_last(fl[0]), .overflow(ovf[0]));
    channel_planar_serializer #(.DATA_WIDTH(32), .CHANNEL_NUM_IN(C), .IMAGE_SIZE(S), .PLANE_GAP(3)) dut1 (
        .clk(clk), .reset(reset), .valid_in(vin[1]), .pxl_in(pin), .pxl_out(pout[1]),
        .valid_out(vout[1]), .plane_last(pl[1]), .frame_last(fl[1]), .overflow(ovf[1]));
    channel_planar_serializer #(.DATA_WIDTH(32), .CHANNEL_NUM_IN(C), .IMAGE_SIZE(S), .PLANE_GAP(15)) dut2 (
        .clk(clk), .reset(reset), .valid_in(vin[2]), .pxl_in(pin), .pxl_out(pout[2]),
        .valid_out(vout[2]), .plane_last(pl[2]), .frame_last(fl[2]), .overflow(ovf[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word(input int f, input int c, input int p);
        return 32'((f << 12) | (c << 8) | p);
    endfunction

    // Model: a completed frame leaves as every pixel of ch0, then ch1, and so on.
    task automatic expect_frame(input int f);
        for (int c = 0; c < C; c++) begin
            for (int p = 0; p < S; p++) begin
                exp_q.push_back('{d: word(f, c, p), pl: (p == S - 1), fl: (c == C - 1 && p == S - 1)});
            end
        end
    endtask

    task automatic scen_begin(input int s);
        sel = s;
        out_cnt = 0; first_cyc = -1; prev_cyc = -1; max_inner = 0; max_all = 0;
        pl_cnt = 0; fl_cnt = 0; prev_pl = 1'b0; prev_fl = 1'b0; last_was_fl = 1'b0;
        first_data = '0; last_fl_data = '0;
        gap_pl_q.delete();
    endtask

    task automatic send_word(input logic [31:0] w);
        @(posedge clk); #1;
        vin = '0;
        vin[sel] = 1'b1;
        pin = w;
        last_drive = cyc;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        vin = '0;
    endtask

    task automatic send_frame(input int f, input bit toggle);
        for (int p = 0; p < S; p++) begin
            for (int c = 0; c < C; c++) begin
                send_word(word(f, c, p));
                if (toggle) idle_cycle();
            end
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d outputs still owed after %0d cycles", name, exp_q.size(), budget);
        end
        repeat (40) @(posedge clk);
        #1;
    endtask

    // Compare process: every valid output of the selected instance is popped
    // against the model; a valid output from any other instance is an error.
    always @(negedge clk) begin
        if (reset) begin
            for (int d = 0; d < 3; d++) begin
                if (vout[d]) begin
                    if (d != sel) begin
                        check("stray_valid", 32'(vout[d]), 32'd0);
                    end else if (exp_q.size() == 0) begin
                        check("unexpected_output", pout[d], 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        int g;
                        e = exp_q.pop_front();
                        check("pxl_out", pout[d], e.d);
                        check("plane_last", 32'(pl[d]), 32'(e.pl));
                        check("frame_last", 32'(fl[d]), 32'(e.fl));
                        if (first_cyc < 0) begin
                            first_cyc  = cyc;
                            first_data = pout[d];
                        end else begin
                            g = cyc - prev_cyc - 1;
                            if (g > max_all) max_all = g;
                            if (prev_pl && !prev_fl) gap_pl_q.push_back(g);
                            else if (g > max_inner) max_inner = g;
                        end
                        if (pl[d]) pl_cnt++;
                        if (fl[d]) begin
                            fl_cnt++;
                            last_fl_data = pout[d];
                        end
                        prev_cyc    = cyc;
                        prev_pl     = pl[d];
                        prev_fl     = fl[d];
                        last_was_fl = fl[d];
                        out_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        scen_begin(0);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_valid_out", 32'(vout[d]), 32'd0);
            check("rst_pxl_out", pout[d], 32'd0);
            check("rst_plane_last", 32'(pl[d]), 32'd0);
            check("rst_frame_last", 32'(fl[d]), 32'd0);
            check("rst_overflow", 32'(ovf[d]), 32'd0);
        end
        @(posedge clk); #1 reset = 1'b1;

        // Single frame at full rate.
        scen_begin(0);
        expect_frame(0);
        check("model_pin_15", exp_q[15].d, 32'h00F);
        check("model_pin_15_pl", 32'(exp_q[15].pl), 32'd1);
        check("model_pin_16", exp_q[16].d, 32'h100);
        check("model_pin_63_fl", 32'(exp_q[63].fl), 32'd1);
        send_frame(0, 1'b0);
        idle_cycle();
        wait_drain("one_frame", 300);
        check("one_frame_latency", 32'(first_cyc - last_drive), 32'd2);
        check("one_frame_count", 32'(out_cnt), 32'd64);
        check("one_frame_first", first_data, 32'h000);
        check("one_frame_last", last_fl_data, 32'h30F);
        check("one_frame_pl_cnt", 32'(pl_cnt), 32'd4);
        check("one_frame_fl_cnt", 32'(fl_cnt), 32'd1);

        // Three back-to-back frames, no plane gap.
        scen_begin(0);
        for (int f = 1; f <= 3; f++) expect_frame(f);
        for (int f = 1; f <= 3; f++) send_frame(f, 1'b0);
        idle_cycle();
        wait_drain("three_frames", 500);
        check("three_frames_count", 32'(out_cnt), 32'd192);
        check("three_frames_contig", 32'(max_all), 32'd0);
        check("three_frames_overflow", 32'(ovf[0]), 32'd0);

        // valid_in toggling every cycle.
        scen_begin(0);
        expect_frame(0);
        send_frame(0, 1'b1);
        wait_drain("toggle", 300);
        check("toggle_count", 32'(out_cnt), 32'd64);
        check("toggle_first", first_data, 32'h000);
        check("toggle_last", last_fl_data, 32'h30F);

        // PLANE_GAP=3 instance.
        scen_begin(1);
        expect_frame(0);
        send_frame(0, 1'b0);
        idle_cycle();
        wait_drain("gap3", 300);
        check("gap3_count", 32'(out_cnt), 32'd64);
        check("gap3_n_plane_gaps", 32'(gap_pl_q.size()), 32'd3);
        for (int i = 0; i < gap_pl_q.size(); i++) check("gap3_plane_gap", 32'(gap_pl_q[i]), 32'd3);
        check("gap3_inner_gap", 32'(max_inner), 32'd0);
        check("gap3_ends_on_fl", 32'(last_was_fl), 32'd1);

        // PLANE_GAP=15 instance, three frames at full rate: frame 3 collides.
        scen_begin(2);
        expect_frame(1);
        expect_frame(2);
        for (int i = 0; i < 3 * FW; i++) begin
            send_word(word(i / FW + 1, i % C, (i % FW) / C));
            if (i == 2 * FW) check("ovf_before_drop", 32'(ovf[2]), 32'd0);
            if (i == 2 * FW + 1) check("ovf_after_drop", 32'(ovf[2]), 32'd1);
        end
        idle_cycle();
        wait_drain("gap15", 800);
        repeat (200) @(posedge clk);
        #1;
        check("gap15_count", 32'(out_cnt), 32'd128);
        check("gap15_ovf_sticky", 32'(ovf[2]), 32'd1);
        check("gap15_n_plane_gaps", 32'(gap_pl_q.size()), 32'd6);
        for (int i = 0; i < gap_pl_q.size(); i++) check("gap15_plane_gap", 32'(gap_pl_q[i]), 32'd15);
        check("gap15_inner_gap", 32'(max_inner), 32'd0);

        // Reset during output of a frame, then a fresh frame.
        scen_begin(0);
        expect_frame(0);
        send_frame(0, 1'b0);
        idle_cycle();
        begin
            int n = 0;
            while (out_cnt < 20 && n < 200) begin
                @(posedge clk);
                n++;
            end
            check("mid_reset_reached", 32'(out_cnt >= 20), 32'd1);
        end
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("mid_reset_valid_out", 32'(vout[0]), 32'd0);
        check("mid_reset_pxl_out", pout[0], 32'd0);
        check("mid_reset_overflow", 32'(ovf[2]), 32'd0);
        exp_q.delete();
        @(posedge clk); #2;
        reset = 1'b1;
        scen_begin(0);
        expect_frame(0);
        send_frame(0, 1'b0);
        idle_cycle();
        wait_drain("after_reset", 300);
        check("after_reset_first", first_data, 32'h000);
        check("after_reset_count", 32'(out_cnt), 32'd64);
        check("after_reset_latency", 32'(first_cyc - last_drive), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/channel_planar_serializer.md
Name: channel_planar_serializer

Overview:
- Converts a pixel-interleaved multichannel stream into the channel-planar stream that the channel-summing adder tree consumes.
- Input order: pixel 0 ch0..ch(C-1), pixel 1 ch0..ch(C-1), and so on.
- Output order: every pixel of ch0, then every pixel of ch1, and so on.
- A ping-pong pair of frame banks lets one frame fill while the previous frame drains. The block sits between the per-pixel producers and the channel accumulators.

Parameters:
- DATA_WIDTH, 32: pixel word width.
- CHANNEL_NUM_IN, 4: channels per frame (C).
- IMAGE_SIZE, 16: pixels per channel plane (S).
- PLANE_GAP, 0: idle cycles inserted between output planes (0..15).
- FRAME_WORDS, C*S: words per bank (derived).
- ADDR_WIDTH, $clog2(FRAME_WORDS): bank address width (derived).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- valid_in  in  1  pxl_in carries a valid word this cycle.
- pxl_in  in  DATA_WIDTH  interleaved input word.
- pxl_out  out  DATA_WIDTH  planar output word.
- valid_out  out  1  pxl_out is valid.
- plane_last  out  1  qualifies the last pixel of a plane (with valid_out).
- frame_last  out  1  qualifies the last word of a frame (with valid_out).
- overflow  out  1  sticky; a word was dropped because no bank was free.

Behaviour:
- Reset (reset=0, asynchronous): pxl_out=0, valid_out=0, plane_last=0, frame_last=0, overflow=0. Both banks go EMPTY, all counters go to 0, wr_bank=0, rd_bank=0.
- Reset asserted mid-frame discards all buffered data and any word in flight.

Write side:
- Counters ch_in (0..C-1) and px_in (0..S-1).
- Each accepted word is written to addr = ch_in*S + px_in in bank wr_bank.
- ch_in increments on every accepted word. On ch_in wrap it returns to 0 and px_in increments.
- On (ch_in=C-1, px_in=S-1):
  - bank wr_bank goes FULL;
  - both counters clear;
  - wr_bank toggles.
- A word is accepted only when bank wr_bank is EMPTY or FILLING. The first accepted word moves EMPTY to FILLING.
- If valid_in=1 and bank wr_bank is FULL or DRAINING: the word is dropped, overflow is set (stays set until reset), and counters do not advance.
- Gaps in valid_in are allowed anywhere. Counters hold during gaps.

Read side FSM (states IDLE, READ, GAP):
- IDLE -> READ when bank rd_bank is FULL. That bank goes DRAINING and rd_addr=0.
- READ issues one read per cycle at rd_addr = 0..FRAME_WORDS-1, in linear order.
- After the read at addr ≡ S-1 (mod S) that is not the final one: go to GAP if PLANE_GAP>0, else stay in READ.
- GAP holds for PLANE_GAP cycles, then returns to READ.
- After the read at addr FRAME_WORDS-1:
  - bank rd_bank goes EMPTY in that same cycle, so it is writable from the next cycle;
  - rd_bank toggles;
  - if the other bank is already FULL, go directly to READ with no idle cycle; otherwise go to IDLE.

Latency and output:
- RAM read is registered: a read issued in cycle t gives valid_out=1 in cycle t+1.
- The first read is issued the cycle after the bank turns FULL. First valid_out therefore comes 2 cycles after the final input word is accepted.
- plane_last=1 on outputs at addr ≡ S-1 (mod S).
- frame_last=1 on the output at addr FRAME_WORDS-1.
- pxl_out holds its last value when valid_out=0.

Simultaneous events:
- A write completing bank X and a read completing bank Y in the same cycle are independent. Both state updates apply.
- If the input targets the bank that is freed in this cycle, it sees EMPTY only in the following cycle. A same-cycle word is dropped and overflow is set.
- With PLANE_GAP=0 and input at full rate, overflow never occurs.

Decomposition:
- Shared package (conv_stream_pkg):
  - bank-state enum (EMPTY, FILLING, FULL, DRAINING);
  - read FSM enum;
  - FRAME_WORDS and ADDR_WIDTH calculation.
- Sub-module planar_bank_ram: simple dual-port RAM of depth 2*FRAME_WORDS, one write port and one registered read port, with the bank select as the address MSB.
- The top level holds the counters, the bank-state registers and the read FSM.

Test Plan:
(Defaults C=4, S=16; input word = (c<<8)|p.)
- One full frame of 64 words, valid_in continuous -> valid_out first asserted 2 cycles after the last input. Output sequence is 0x000..0x00F, 0x100..0x10F, 0x200..0x20F, 0x300..0x30F. plane_last is high on 0x00F, 0x10F, 0x20F, 0x30F. frame_last is high only on 0x30F.
- Three back-to-back frames at full rate, PLANE_GAP=0 -> 192 contiguous valid_out cycles in the correct planar order, overflow=0.
- Input with valid_in toggling 1/0 every cycle -> output identical to the first scenario, delayed.
- PLANE_GAP=3, one frame -> exactly 3 idle cycles after each of the first three plane_last outputs, and none after frame_last.
- PLANE_GAP=15, three frames at full rate -> the third frame's first word is dropped, overflow rises and stays 1, and frames 1 and 2 are output intact.
- reset driven low for 1 cycle in the middle of frame 1's output -> valid_out=0 immediately (asynchronous). A fresh frame sent afterwards outputs correctly starting at 0x000.
